// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM (combinational read, clocked write)
// between the CPU (port A) and the loader/debug port (port B).
//
// Each access takes three cycles: IDLE (arbitrate and latch the request),
// ACCESS (RAM addressed, write strobe or read capture) and DONE (ack pulse).
// When both ports are eligible, the port that was not served last wins.
// While b_hold is high, port A is never granted.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A request (held until a_ack)
//   a_ack, a_rdata             port A completion pulse and read data
//   b_*                        same as port A, for port B
//   b_hold                     blocks new port A grants
//   ram_addr, ram_din          registered RAM address and write data
//   ram_write_en               RAM write strobe (high in ACCESS for writes)
//   ram_dout                   RAM read data, combinational from ram_addr
//   busy                       high whenever the FSM is not in IDLE
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    input  logic                  b_hold,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_write_en,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_e                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic                    gnt_q, gnt_d;
    logic                    lat_we_q, lat_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_din_q, ram_din_d;
    logic                    a_ack_q, a_ack_d;
    logic                    b_ack_q, b_ack_d;
    logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0]   b_rdata_q, b_rdata_d;
    logic                    busy_q, busy_d;

    logic                    elig_a_s;
    logic                    elig_b_s;
    logic                    sel_s;

    // Next-state logic: arbitration in IDLE, read capture in ACCESS, priority update in DONE.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        gnt_d     = gnt_q;
        lat_we_d  = lat_we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d = ram_din_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        elig_a_s  = a_req && !b_hold;
        elig_b_s  = b_req;

        // Contention is resolved by prio; otherwise the lone eligible port wins.
        if (elig_a_s && elig_b_s) begin
            sel_s = prio_q;
        end else if (elig_b_s) begin
            sel_s = PORT_B;
        end else begin
            sel_s = PORT_A;
        end

        case (state_q)
            ST_IDLE: begin
                if (elig_a_s || elig_b_s) begin
                    gnt_d = sel_s;
                    if (sel_s == PORT_B) begin
                        lat_we_d   = b_we;
                        ram_addr_d = b_addr;
                        ram_din_d  = b_wdata;
                    end else begin
                        lat_we_d   = a_we;
                        ram_addr_d = a_addr;
                        ram_din_d  = a_wdata;
                    end
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Writes leave both read-data registers untouched.
                if (!lat_we_q) begin
                    if (gnt_q == PORT_B) begin
                        b_rdata_d = ram_dout;
                    end else begin
                        a_rdata_d = ram_dout;
                    end
                end else begin
                    a_rdata_d = a_rdata_q;
                end
                // Acks are registered so they appear exactly in DONE.
                if (gnt_q == PORT_B) begin
                    b_ack_d = 1'b1;
                end else begin
                    a_ack_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                prio_d  = ~gnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prio_q     <= PORT_A;
            gnt_q      <= PORT_A;
            lat_we_q   <= 1'b0;
            ram_addr_q <= {ADDR_WIDTH{1'b0}};
            ram_din_q  <= {DATA_WIDTH{1'b0}};
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= {DATA_WIDTH{1'b0}};
            b_rdata_q  <= {DATA_WIDTH{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            gnt_q      <= gnt_d;
            lat_we_q   <= lat_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            busy_q     <= busy_d;
        end
    end

    // reset gates the strobe directly so an aborted write never commits.
    assign ram_write_en = (state_q == ST_ACCESS) && lat_we_q && !reset;

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a RAM model on the RAM pins, a transaction-level
// reference model compared against every output on every falling edge, and
// directed scenarios with hand-computed expectations followed by random traffic.
module tb_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we, b_hold;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_write_en;
    logic [DW-1:0] ram_dout;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .b_hold(b_hold),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_write_en(ram_write_en),
        .ram_dout(ram_dout), .busy(busy)
    );

    // ---------------- RAM model (combinational read, clocked write) ----------
    logic [DW-1:0] mem [0:255];
    assign ram_dout = mem[ram_addr];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        mem[0] = 12'h0F9;
        mem[1] = 12'h090;
        mem[2] = 12'h9F1;
        forever begin
            @(posedge clk);
            if (ram_write_en === 1'b1) mem[ram_addr] = ram_din;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------------------------------
    // One outstanding transaction with its age: age 0 = RAM addressed,
    // age 1 = acknowledged. The model advances on the falling edge using the
    // inputs that the next rising edge will sample.
    logic [DW-1:0] ref_mem [0:255];
    bit            m_active, m_port, m_we, m_prio;
    int            m_age;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_rdata [0:1];
    bit            prev_we;
    int            a_ack_cnt = 0, b_ack_cnt = 0, wr_cnt = 0;
    logic [AW-1:0] last_wr_addr;

    task automatic model_step();
        bit ea, eb;
        if (reset) begin
            m_active = 1'b0; m_age = 0; m_prio = 1'b0; m_we = 1'b0;
            m_port = 1'b0; m_addr = '0; m_din = '0;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (!m_active) begin
            ea = a_req && !b_hold;
            eb = b_req;
            if (ea || eb) begin
                m_port   = (ea && eb) ? m_prio : eb;
                m_we     = m_port ? b_we : a_we;
                m_addr   = m_port ? b_addr : a_addr;
                m_din    = m_port ? b_wdata : a_wdata;
                m_active = 1'b1;
                m_age    = 0;
            end
        end else if (m_age == 0) begin
            if (m_we) ref_mem[m_addr] = m_din;
            else      m_rdata[m_port] = ref_mem[m_addr];
            m_age = 1;
        end else begin
            m_prio   = !m_port;
            m_active = 1'b0;
        end
    endtask

    // Compare process: every output against the model on every falling edge.
    initial begin
        @(negedge clk);
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        prev_we = 1'b0;
        model_step();
        forever begin
            @(negedge clk);
            chk("a_ack", a_ack, 32'(m_active && m_age == 1 && !m_port));
            chk("b_ack", b_ack, 32'(m_active && m_age == 1 && m_port));
            chk("busy", busy, 32'(m_active));
            chk("ram_write_en", ram_write_en, 32'(m_active && m_age == 0 && m_we && !reset));
            chk("ram_addr", ram_addr, 32'(m_addr));
            chk("ram_din", ram_din, 32'(m_din));
            chk("a_rdata", a_rdata, 32'(m_rdata[0]));
            chk("b_rdata", b_rdata, 32'(m_rdata[1]));
            chk("acks_exclusive", 32'(a_ack === 1'b1 && b_ack === 1'b1), 32'd0);
            chk("we_single_cycle", 32'(prev_we && ram_write_en === 1'b1), 32'd0);
            prev_we = (ram_write_en === 1'b1);
            if (a_ack === 1'b1) a_ack_cnt++;
            if (b_ack === 1'b1) b_ack_cnt++;
            if (ram_write_en === 1'b1) begin
                wr_cnt++;
                last_wr_addr = ram_addr;
            end
            model_step();
        end
    end

    // ---------------- stimulus ------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        b_hold = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits up to budget cycles for the ack of a port; cycles = edges taken.
    task automatic wait_ack(input bit port, input int budget, output int cycles);
        bit got;
        got = 1'b0;
        cycles = -1;
        for (int i = 1; i <= budget && !got; i++) begin
            tick();
            if ((port ? b_ack : a_ack) === 1'b1) begin
                got = 1'b1;
                cycles = i;
            end
        end
        if (!got) chk(port ? "b_ack_timeout" : "a_ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int c, base_a, base_b, base_w;
        int ta1, ta2, tb1;
        logic [DW-1:0] orig;
        int seq[$];

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        // Reset state
        chk("rst_busy", busy, 32'd0);
        chk("rst_a_ack", a_ack, 32'd0);
        chk("rst_b_ack", b_ack, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        reset = 1'b0;

        // Single read by A
        base_b = b_ack_cnt;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00;
        wait_ack(1'b0, 6, c);
        chk("t1_latency", c, 32'd2);
        chk("t1_a_rdata", a_rdata, 32'h0F9);
        a_req = 1'b0;
        tick();
        chk("t1_no_b_ack", b_ack_cnt - base_b, 32'd0);

        // B writes then reads back
        do_reset();
        base_w = wr_cnt;
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'hAB; b_wdata = 12'h5A1;
        wait_ack(1'b1, 6, c);
        b_we = 1'b0; b_wdata = 12'h000;
        wait_ack(1'b1, 6, c);
        chk("t2_read_spacing", c, 32'd3);
        chk("t2_b_rdata", b_rdata, 32'h5A1);
        b_req = 1'b0;
        chk("t2_write_count", wr_cnt - base_w, 32'd1);
        chk("t2_write_addr", last_wr_addr, 32'hAB);
        chk("t2_a_rdata", a_rdata, 32'd0);

        // Simultaneous requests: A first, then B wins the next contention
        do_reset();
        ta1 = -1; ta2 = -1; tb1 = -1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (a_ack === 1'b1) begin
                if (ta1 < 0) ta1 = i; else if (ta2 < 0) ta2 = i;
                chk("t3_a_rdata", a_rdata, 32'h090);
            end
            if (b_ack === 1'b1) begin
                if (tb1 < 0) tb1 = i;
                chk("t3_b_rdata", b_rdata, 32'h9F1);
                b_req = 1'b0;
            end
        end
        a_req = 1'b0;
        chk("t3_a_first", ta1, 32'd2);
        chk("t3_b_second", tb1, 32'd5);
        chk("t3_a_third", ta2, 32'd8);

        // Exclusive hold: B writes 4 times, A starved until hold drops
        do_reset();
        base_a = a_ack_cnt;
        b_hold = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h03;
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = DW'($urandom);
        for (int k = 0; k < 4; k++) begin
            wait_ack(1'b1, 6, c);
            chk("t4_b_spacing", c, (k == 0) ? 32'd2 : 32'd3);
            b_addr = AW'(8'h21 + k);
            b_wdata = DW'($urandom);
        end
        b_req = 1'b0;
        b_hold = 1'b0;
        chk("t4_no_a_ack", a_ack_cnt - base_a, 32'd0);
        wait_ack(1'b0, 3, c);
        a_req = 1'b0;

        // Reset during the ACCESS cycle of a write
        do_reset();
        base_a = a_ack_cnt;
        orig = mem[8'h10];
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 12'hFFF;
        tick();
        chk("t5_busy_access", busy, 32'd1);
        reset = 1'b1;
        a_req = 1'b0;
        #1;
        chk("t5_we_suppressed", ram_write_en, 32'd0);
        tick();
        chk("t5_mem_kept", mem[8'h10], 32'(orig));
        chk("t5_busy", busy, 32'd0);
        chk("t5_a_ack", a_ack, 32'd0);
        chk("t5_ram_addr", ram_addr, 32'd0);
        chk("t5_ram_din", ram_din, 32'd0);
        chk("t5_we", ram_write_en, 32'd0);
        reset = 1'b0;
        repeat (4) tick();
        chk("t5_no_ack", a_ack_cnt - base_a, 32'd0);

        // Continuous contention for 30 cycles with random fields
        do_reset();
        base_a = a_ack_cnt;
        base_b = b_ack_cnt;
        a_req = 1'b1;
        b_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
            b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
            tick();
            if (a_ack === 1'b1) seq.push_back(0);
            if (b_ack === 1'b1) seq.push_back(1);
        end
        clear_inputs();
        chk("t6_a_count", a_ack_cnt - base_a, 32'd5);
        chk("t6_b_count", b_ack_cnt - base_b, 32'd5);
        chk("t6_seq_len", seq.size(), 32'd10);
        if (seq.size() > 0) chk("t6_a_first", seq[0], 32'd0);
        for (int k = 1; k < seq.size(); k++)
            chk("t6_alternate", 32'(seq[k] != seq[k-1]), 32'd1);

        // Random traffic, checked cycle by cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 49) == 0);
            a_req   = ($urandom_range(0, 3) != 0);
            b_req   = ($urandom_range(0, 2) == 0);
            b_hold  = ($urandom_range(0, 4) == 0);
            a_we    = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
            b_we    = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
            tick();
        end
        reset = 1'b0;
        clear_inputs();
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port program/data RAM (8-bit address, 12-bit word, combinational read, clocked write) between the CPU (port A) and the program loader/debug port (port B). It sits between both requesters and the RAM's `din`/`addr`/`write_en`/`dout` pins. It serialises accesses through a three-state FSM with round-robin priority. Port B can take exclusive ownership to reload the program while the CPU is stalled.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: RAM address width.
- `DATA_WIDTH`, default 12: RAM word width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_req`  in  1  port A request; held high until `a_ack`.
- `a_we`  in  1  port A write (1) or read (0).
- `a_addr`  in  ADDR_WIDTH  port A address.
- `a_wdata`  in  DATA_WIDTH  port A write data.
- `a_ack`  out  1  one-cycle completion pulse for port A.
- `a_rdata`  out  DATA_WIDTH  port A read data; valid while `a_ack` is high and held until the next port A read completes.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as port A, for port B.
- `b_hold`  in  1  exclusive ownership for port B; port A is never granted while this is high.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`; registered.
- `ram_din`  out  DATA_WIDTH  to RAM `din`; registered.
- `ram_write_en`  out  1  to RAM `write_en`.
- `ram_dout`  in  DATA_WIDTH  from RAM `dout`; combinational from `ram_addr`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset enters IDLE.
- **IDLE**
  - Eligible requesters: A if `a_req && !b_hold`; B if `b_req`.
  - If none is eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the side selected by the priority pointer `prio`.
  - On a grant: latch that port's `we`, `addr` and `wdata` into `lat_we`, `ram_addr` and `ram_din`; record the granted port in `gnt`; go to ACCESS. The requester may change its fields after this edge.
- **ACCESS**
  - `ram_write_en = lat_we && !reset`, combinational from the state register.
  - On a read, capture `ram_dout` into the granted port's `rdata` register at the closing edge.
  - On a write, leave both `rdata` registers unchanged.
  - Go to DONE.
- **DONE**
  - Assert the `ack` of the granted port (registered, exactly one cycle).
  - Set `prio` to the port that was not granted.
  - Requests are not sampled in this state.
  - Go to IDLE.
- Handshake: a requester that sees `ack` may drop `req` on that same edge. If `req` is still high in the following IDLE cycle, it is a new request.
- `b_hold` rising mid-transaction does not abort an A transaction already in ACCESS or DONE; it blocks only subsequent A grants.
- Address and data pass straight through; no arithmetic. Addresses cover the full 0 to 2^ADDR_WIDTH-1 range, with no wrap logic.
- Reset values:
  - FSM in IDLE; `prio` = A.
  - `a_ack`, `b_ack`, `busy`, `ram_write_en` = 0.
  - `a_rdata`, `b_rdata`, `ram_addr`, `ram_din`, `lat_we` = 0.
- Reset mid-operation:
  - `reset` high during ACCESS suppresses `ram_write_en` combinationally, so no write commits on that edge.
  - No `ack` is produced for the aborted transaction.

## Timing
- Cycle n: IDLE samples `req`.
- Cycle n+1: ACCESS; RAM is addressed; a write commits at the end of n+1.
- Cycle n+2: DONE; `ack` is high and `rdata` is valid.
- Latency from request sampled to `ack`: 2 cycles.
- Throughput: one access per 3 cycles; a continuous single requester is acked every 3rd cycle.
- Both requesters continuously active (`b_hold` low): grants alternate A, B, A, B, and so on.
- `ram_write_en` is never high for more than one consecutive cycle.
- `busy` is high in ACCESS and DONE.

## Test plan
- **Single read.** Writable RAM model preloaded with addr 0 = 12'h0F9. Release reset, hold `a_req` with `a_we`=0, `a_addr`=0 → `a_ack` high 2 cycles after first sample, with `a_rdata`=12'h0F9. `b_ack` stays 0.
- **Write then read.** Port B writes 12'h5A1 to address 8'hAB, then reads 8'hAB → `ram_write_en` is high for exactly one cycle with `ram_addr`=8'hAB; the read returns `b_rdata`=12'h5A1. Afterwards `a_rdata` is still 0.
- **Simultaneous requests after reset.** A reads address 1 (12'h090), B reads address 2 (12'h9F1) → A is acked first, B 3 cycles later. A second simultaneous pair is served B first.
- **Exclusive hold.** Assert `b_hold` and keep `a_req` high; B performs 4 writes → `a_ack` stays 0 throughout and B is acked every 3 cycles. Drop `b_hold` → `a_ack` within 3 cycles.
- **Reset during write.** Assert `reset` during ACCESS of a write of 12'hFFF to address 8'h10 → the memory word is unchanged, no `ack` is produced, and on the next cycle every output equals its reset value with the FSM in IDLE.
- **Continuous contention.** Hold `a_req` and `b_req` high for 30 cycles → exactly 5 `a_ack` and 5 `b_ack` pulses, strictly alternating, and never both high in the same cycle.
